// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one single-ported unified memory to either the
// instruction-fetch stage or the data-memory stage. It runs a fixed-latency
// access of MEM_LAT cycles and then returns read data with a one-cycle ack.
// Every output is a register or is decoded from registered state, so no input
// reaches mem_* or the acks combinationally.
module mem_port_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   input  logic [3:0]        d_xfersize,
   output logic [63:0]       d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [3:0]        mem_xfersize,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

   // Counter value on the final access cycle; cnt stops here and never wraps.
   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t            state_reg;
   owner_t            owner_reg;
   owner_t            last_owner_reg;
   logic [3:0]        cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              we_reg;
   logic [63:0]       wdata_reg;
   logic [3:0]        xfersize_reg;
   logic [31:0]       if_rdata_reg;
   logic [63:0]       d_rdata_reg;

   // Arbitration FSM. It latches the granted request, counts the access and captures read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= FETCH;
         last_owner_reg <= FETCH;
         cnt_reg        <= 4'd0;
         addr_reg       <= '0;
         we_reg         <= 1'b0;
         wdata_reg      <= 64'd0;
         xfersize_reg   <= 4'd0;
         if_rdata_reg   <= 32'd0;
         d_rdata_reg    <= 64'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (if_req || d_req) begin
                  cnt_reg   <= 4'd0;
                  state_reg <= ACCESS;
                  // On a tie, the port that did not own the previous access wins.
                  if (d_req && (!if_req || last_owner_reg == FETCH)) begin
                     owner_reg    <= DATA;
                     addr_reg     <= d_addr;
                     we_reg       <= d_we;
                     wdata_reg    <= d_wdata;
                     xfersize_reg <= d_xfersize;
                  end else begin
                     owner_reg    <= FETCH;
                     addr_reg     <= if_addr;
                     we_reg       <= 1'b0;
                     wdata_reg    <= 64'd0;
                     xfersize_reg <= 4'b0100;
                  end
               end
            end
            ACCESS: begin
               if (cnt_reg == CNT_LAST) begin
                  // A store leaves both read-data registers untouched.
                  if (!we_reg) begin
                     if (owner_reg == FETCH) begin
                        if_rdata_reg <= mem_rdata[31:0];
                     end else begin
                        d_rdata_reg <= mem_rdata;
                     end
                  end
                  last_owner_reg <= owner_reg;
                  state_reg      <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state only. When reset clears the state, mem_en and mem_we drop at once.
   assign busy         = (state_reg != IDLE);
   assign mem_en       = (state_reg == ACCESS);
   assign mem_we       = (state_reg == ACCESS) && we_reg;
   assign mem_addr     = addr_reg;
   assign mem_wdata    = wdata_reg;
   assign mem_xfersize = xfersize_reg;
   assign if_ack       = (state_reg == DONE) && (owner_reg == FETCH);
   assign d_ack        = (state_reg == DONE) && (owner_reg == DATA);
   assign if_rdata     = if_rdata_reg;
   assign d_rdata      = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. u0 uses MEM_LAT=2 and u1 uses MEM_LAT=1. Each
// instance has a small behavioural memory model that answers combinationally
// and writes on the clock edge.
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // u0 signals
   logic        if_req, d_req, d_we;
   logic [63:0] if_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_rdata;
   logic [3:0]  d_xfersize, mem_xfersize;
   logic        if_ack, d_ack, mem_en, mem_we, busy;

   // u1 signals
   logic        if_req1;
   logic [63:0] if_addr1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [31:0] if_rdata1;
   logic [3:0]  mem_xfersize1;
   logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;

   mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(64)) u0 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_xfersize(d_xfersize), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_xfersize(mem_xfersize), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(64)) u1 (
      .clk(clk), .reset(reset),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(64'd0), .d_wdata(64'd0),
      .d_xfersize(4'd0), .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_xfersize(mem_xfersize1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   // Memory models: 256 doublewords, indexed by address bits [10:3]
   logic [63:0] mem0 [256];
   logic [63:0] mem1 [256];
   assign mem_rdata  = mem0[mem_addr[10:3]];
   assign mem_rdata1 = mem1[mem_addr1[10:3]];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem0[mem_addr[10:3]] = mem_wdata;
      if (mem_en1 && mem_we1) mem1[mem_addr1[10:3]] = mem_wdata1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          is_data;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [3:0]  size;
      logic [63:0] exp_rdata;
   } vec_t;

   // Single isolated access on u0. The call starts in an IDLE cycle (cycle 0) and
   // returns in the next IDLE cycle (cycle LAT+2).
   task automatic run_vec(input vec_t v, input int idx);
      if (v.is_data) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_xfersize = v.size;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 1; c <= LAT + 1; c++) begin
         step();
         if (c <= LAT) begin
            chk("acc_mem_en", 64'(mem_en), 64'd1);
            chk("acc_mem_we", 64'(mem_we), 64'(v.we));
            chk("acc_mem_addr", mem_addr, v.addr);
            chk("acc_mem_xfersize", 64'(mem_xfersize), v.is_data ? 64'(v.size) : 64'd4);
            if (v.we) chk("acc_mem_wdata", mem_wdata, v.wdata);
            chk("acc_if_ack", 64'(if_ack), 64'd0);
            chk("acc_d_ack", 64'(d_ack), 64'd0);
         end else begin
            chk("done_mem_en", 64'(mem_en), 64'd0);
            chk("done_busy", 64'(busy), 64'd1);
            chk("done_if_ack", 64'(if_ack), v.is_data ? 64'd0 : 64'd1);
            chk("done_d_ack", 64'(d_ack), v.is_data ? 64'd1 : 64'd0);
            if (v.is_data) chk("done_d_rdata", d_rdata, v.exp_rdata);
            else           chk("done_if_rdata", 64'(if_rdata), v.exp_rdata);
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'd0);
      $display("txn %0d data=%0d we=%0d addr=%h if_rdata=%h d_rdata=%h", idx, v.is_data, v.we,
               v.addr, if_rdata, d_rdata);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   vec_t vecs[7];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 64'd0;
         mem1[i] = 64'd0;
      end
      mem0[8]  = 64'h00000000_91000421;   // 0x40
      mem1[8]  = 64'h00000000_91000421;   // 0x40
      mem1[9]  = 64'h11112222_33334444;   // 0x48
      mem1[10] = 64'h77778888_55556666;   // 0x50

      vecs[0] = '{1'b0, 1'b0, 64'h40, 64'h0, 4'd4, 64'h0000_0000_9100_0421};
      vecs[1] = '{1'b1, 1'b1, 64'h80, 64'hDEADBEEF_CAFEF00D, 4'd8, 64'h0};
      vecs[2] = '{1'b1, 1'b0, 64'h80, 64'h0, 4'd8, 64'hDEADBEEF_CAFEF00D};
      vecs[3] = '{1'b1, 1'b1, 64'h88, 64'h01234567_89ABCDEF, 4'd4, 64'hDEADBEEF_CAFEF00D};
      vecs[4] = '{1'b0, 1'b0, 64'h88, 64'h0, 4'd4, 64'h0000_0000_89AB_CDEF};
      vecs[5] = '{1'b1, 1'b0, 64'h40, 64'h0, 4'd4, 64'h0000_0000_9100_0421};
      vecs[6] = '{1'b0, 1'b0, 64'h80, 64'h0, 4'd4, 64'h0000_0000_CAFE_F00D};

      reset = 1'b1;
      if_req = 1'b0; if_addr = 64'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_xfersize = 4'd0;
      if_req1 = 1'b0; if_addr1 = 64'd0;
      step();
      step();
      // Reset state
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
      chk("rst_if_rdata", 64'(if_rdata), 64'd0);
      chk("rst_d_rdata", d_rdata, 64'd0);
      chk("rst_busy1", 64'(busy1), 64'd0);
      reset = 1'b0;

      // Table of isolated accesses
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Both requests held continuously after reset: DATA, FETCH, DATA, FETCH
      pulse_reset();
      if_req = 1'b1; if_addr = 64'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80; d_xfersize = 4'd8;
      for (int c = 1; c <= 16; c++) begin
         step();
         chk("tie_d_ack", 64'(d_ack), (c == 3 || c == 11) ? 64'd1 : 64'd0);
         chk("tie_if_ack", 64'(if_ack), (c == 7 || c == 15) ? 64'd1 : 64'd0);
         chk("tie_mem_en", 64'(mem_en), (c % 4 == 1 || c % 4 == 2) ? 64'd1 : 64'd0);
         if (c % 8 == 1 || c % 8 == 2) chk("tie_addr_data", mem_addr, 64'h80);
         if (c % 8 == 5 || c % 8 == 6) chk("tie_addr_fetch", mem_addr, 64'h40);
         if (c == 15) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         if (c == 16) chk("tie_idle", 64'(busy), 64'd0);
      end
      $display("txn tie sequence done d_rdata=%h if_rdata=%h", d_rdata, if_rdata);

      // Data request arriving during a fetch waits for IDLE; d_addr changes are ignored
      if_req = 1'b1; if_addr = 64'h40;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 2) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80; d_xfersize = 4'd8;
         end
         if (c == 3) begin
            chk("busyreq_if_ack", 64'(if_ack), 64'd1);
            if_req = 1'b0;
         end
         if (c == 4) chk("busyreq_gap_idle", 64'(busy), 64'd0);
         if (c == 5) begin
            chk("busyreq_access", 64'(mem_en), 64'd1);
            chk("busyreq_addr5", mem_addr, 64'h80);
            d_addr = 64'h100;
         end
         if (c == 6) chk("busyreq_addr_held", mem_addr, 64'h80);
         chk("busyreq_d_ack", 64'(d_ack), (c == 7) ? 64'd1 : 64'd0);
         if (c == 7) begin
            chk("busyreq_d_rdata", d_rdata, 64'hDEADBEEF_CAFEF00D);
            d_req = 1'b0;
         end
      end
      $display("txn request-during-busy done d_rdata=%h", d_rdata);

      // Reset in the middle of a store
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'hC0; d_wdata = 64'h5555AAAA_5555AAAA; d_xfersize = 4'd8;
      step();
      chk("rstmid_mem_we_before", 64'(mem_we), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_mem_en", 64'(mem_en), 64'd0);
      chk("rstmid_mem_we", 64'(mem_we), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_d_rdata", d_rdata, 64'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("rstmid_no_ack", 64'(d_ack), 64'd0);
      end
      reset = 1'b0;
      if_req = 1'b1; if_addr = 64'h40;
      d_we = 1'b0; d_addr = 64'h80;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) begin
            chk("rstmid_tie_addr", mem_addr, 64'h80);
            chk("rstmid_tie_we", 64'(mem_we), 64'd0);
         end
         chk("rstmid_d_ack", 64'(d_ack), (c == 3) ? 64'd1 : 64'd0);
         chk("rstmid_if_ack", 64'(if_ack), (c == 7) ? 64'd1 : 64'd0);
         if (c == 3) begin
            chk("rstmid_d_rdata_load", d_rdata, 64'hDEADBEEF_CAFEF00D);
            d_req = 1'b0;
         end
         if (c == 7) if_req = 1'b0;
      end
      chk("rstmid_no_store", mem0[24], 64'd0);
      $display("txn reset-mid-store done d_rdata=%h", d_rdata);

      // MEM_LAT=1: ack in cycle 2, back-to-back fetches every 3 cycles
      if_req1 = 1'b1; if_addr1 = 64'h40;
      for (int c = 1; c <= 9; c++) begin
         step();
         chk("lat1_mem_en", 64'(mem_en1), (c % 3 == 1 && c < 9) ? 64'd1 : 64'd0);
         chk("lat1_if_ack", 64'(if_ack1), (c % 3 == 2) ? 64'd1 : 64'd0);
         chk("lat1_d_ack", 64'(d_ack1), 64'd0);
         if (c == 2) begin
            chk("lat1_rdata0", 64'(if_rdata1), 64'h91000421);
            if_addr1 = 64'h48;
         end
         if (c == 4) chk("lat1_addr1", mem_addr1, 64'h48);
         if (c == 5) begin
            chk("lat1_rdata1", 64'(if_rdata1), 64'h33334444);
            if_addr1 = 64'h50;
         end
         if (c == 8) begin
            chk("lat1_rdata2", 64'(if_rdata1), 64'h55556666);
            if_req1 = 1'b0;
         end
         if (c == 9) chk("lat1_idle", 64'(busy1), 64'd0);
      end
      $display("txn mem_lat1 sweep done if_rdata=%h", if_rdata1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
